// File: rtl/dispatch_queue_pkg.sv
// dispatch_queue_pkg: constants and types shared by the dispatch queue slice.
//   - ALU operation / result-select codes used by the decode->execute bundle
//   - DISPATCH_DEPTH_DEFAULT: default FIFO depth
//   - dq_entry_t: one stored decoder bundle
package dispatch_queue_pkg;

    localparam int unsigned DISPATCH_DEPTH_DEFAULT = 4;

    localparam logic [7:0] ALU_NOP  = 8'h00;
    localparam logic [7:0] ALU_ORI  = 8'h25;
    localparam logic [7:0] ALU_ADDI = 8'h55;
    localparam logic [7:0] ALU_SLTI = 8'h57;

    localparam logic [2:0] ALU_SEL_NOP   = 3'b000;
    localparam logic [2:0] ALU_SEL_LOGIC = 3'b001;
    localparam logic [2:0] ALU_SEL_ARITH = 3'b100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        reg_write_en;
        logic [4:0]  reg_write_addr;
        logic        reg1_read_en;
        logic [4:0]  reg1_read_addr;
        logic        reg2_read_en;
        logic [4:0]  reg2_read_addr;
        logic        ine;
    } dq_entry_t;

    localparam dq_entry_t DQ_ENTRY_RESET = '{aluop: ALU_NOP, alusel: ALU_SEL_NOP, default: '0};

endpackage

// File: rtl/dispatch_scoreboard.sv
// dispatch_scoreboard: 32-entry register busy table.
//   set_en/set_addr : mark a destination in flight (issue); r0 is never marked
//   clr_en/clr_addr : writeback clears the bit; a same-cycle set of the same
//                     register wins
//   rd1_*/rd2_*     : source query, hazard=1 when an enabled source is busy
// Build option DISPATCH_WB_BYPASS_EN: the current-cycle writeback clear is
// applied to the query combinationally.
module dispatch_scoreboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic       rd1_en,
    input  logic [4:0] rd1_addr,
    input  logic       rd2_en,
    input  logic [4:0] rd2_addr,
    output logic       hazard
);

    logic [31:0] busy;
    logic [31:0] busy_view;

    // The set is written after the clear so it takes priority on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_addr] <= 1'b0;
            end
            if (set_en && (set_addr != 5'd0)) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        busy_view = busy;
`ifdef DISPATCH_WB_BYPASS_EN
        if (clr_en) begin
            busy_view[clr_addr] = 1'b0;
        end
`endif
        busy_view[0] = 1'b0;
    end

    assign hazard = (rd1_en && busy_view[rd1_addr]) || (rd2_en && busy_view[rd2_addr]);

endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order decode->execute buffer with register scoreboard.
//   in_*  : decoder bundle, accepted when in_valid && in_ready
//   out_* : head entry fields, issued when out_valid && out_ready
//   wb_*  : writeback port clearing scoreboard busy bits
//   flush : empties the queue (scoreboard kept), count: occupancy
// Build option DISPATCH_WB_BYPASS_EN (see dispatch_scoreboard).
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DISPATCH_DEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic             in_inst_valid,
    input  logic             in_reg_write_en,
    input  logic [4:0]       in_reg_write_addr,
    input  logic [7:0]       in_aluop,
    input  logic [2:0]       in_alusel,
    input  logic [31:0]      in_imm,
    input  logic             in_reg1_read_en,
    input  logic             in_reg2_read_en,
    input  logic [4:0]       in_reg1_read_addr,
    input  logic [4:0]       in_reg2_read_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_imm,
    output logic [7:0]       out_aluop,
    output logic [2:0]       out_alusel,
    output logic             out_reg_write_en,
    output logic [4:0]       out_reg_write_addr,
    output logic [4:0]       out_reg1_read_addr,
    output logic [4:0]       out_reg2_read_addr,
    output logic             out_reg1_read_en,
    output logic             out_reg2_read_en,
    output logic             out_ine,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    dq_entry_t          mem [DEPTH];
    dq_entry_t          head;
    dq_entry_t          new_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               hazard;
    logic               push;
    logic               pop;

    assign in_ready  = (count != FULL_COUNT);
    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0) && !hazard && !flush;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    // Unrecognised opcodes are neutralised on entry so they never touch the
    // scoreboard and execute sees a NOP flagged with ine.
    always_comb begin
        new_entry.pc             = in_pc;
        new_entry.inst           = in_inst;
        new_entry.imm            = in_imm;
        new_entry.reg_write_addr = in_reg_write_addr;
        new_entry.reg1_read_addr = in_reg1_read_addr;
        new_entry.reg2_read_addr = in_reg2_read_addr;
        new_entry.aluop          = in_aluop;
        new_entry.alusel         = in_alusel;
        new_entry.reg_write_en   = in_reg_write_en;
        new_entry.reg1_read_en   = in_reg1_read_en;
        new_entry.reg2_read_en   = in_reg2_read_en;
        new_entry.ine            = 1'b0;
        if (!in_inst_valid) begin
            new_entry.aluop        = ALU_NOP;
            new_entry.alusel       = ALU_SEL_NOP;
            new_entry.reg_write_en = 1'b0;
            new_entry.reg1_read_en = 1'b0;
            new_entry.reg2_read_en = 1'b0;
            new_entry.ine          = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: DQ_ENTRY_RESET};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    dispatch_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (pop && head.reg_write_en),
        .set_addr (head.reg_write_addr),
        .clr_en   (wb_en),
        .clr_addr (wb_addr),
        .rd1_en   (head.reg1_read_en),
        .rd1_addr (head.reg1_read_addr),
        .rd2_en   (head.reg2_read_en),
        .rd2_addr (head.reg2_read_addr),
        .hazard   (hazard)
    );

    assign out_pc             = head.pc;
    assign out_inst           = head.inst;
    assign out_imm            = head.imm;
    assign out_aluop          = head.aluop;
    assign out_alusel         = head.alusel;
    assign out_reg_write_en   = head.reg_write_en;
    assign out_reg_write_addr = head.reg_write_addr;
    assign out_reg1_read_en   = head.reg1_read_en;
    assign out_reg1_read_addr = head.reg1_read_addr;
    assign out_reg2_read_en   = head.reg2_read_en;
    assign out_reg2_read_addr = head.reg2_read_addr;
    assign out_ine            = head.ine;

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: self-checking bench for dispatch_queue (DEPTH=4).
// Expected issue bundles are queued when pushes are accepted and compared
// whenever the DUT issues.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic        iv;
        logic        we;
        logic [4:0]  wa;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic        r1e;
        logic [4:0]  r1a;
        logic        r2e;
        logic [4:0]  r2a;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0, in_inst = '0, in_imm = '0;
    logic        in_inst_valid = 1'b0, in_reg_write_en = 1'b0;
    logic [4:0]  in_reg_write_addr = '0;
    logic [7:0]  in_aluop = '0;
    logic [2:0]  in_alusel = '0;
    logic        in_reg1_read_en = 1'b0, in_reg2_read_en = 1'b0;
    logic [4:0]  in_reg1_read_addr = '0, in_reg2_read_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_inst, out_imm;
    logic [7:0]  out_aluop;
    logic [2:0]  out_alusel;
    logic        out_reg_write_en;
    logic [4:0]  out_reg_write_addr, out_reg1_read_addr, out_reg2_read_addr;
    logic        out_reg1_read_en, out_reg2_read_en, out_ine;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;
    logic [125:0] exp_q [$];
    logic [31:0]  busy_snap;

    always #5 clk = ~clk;

    dispatch_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_inst_valid(in_inst_valid),
        .in_reg_write_en(in_reg_write_en), .in_reg_write_addr(in_reg_write_addr),
        .in_aluop(in_aluop), .in_alusel(in_alusel), .in_imm(in_imm),
        .in_reg1_read_en(in_reg1_read_en), .in_reg2_read_en(in_reg2_read_en),
        .in_reg1_read_addr(in_reg1_read_addr), .in_reg2_read_addr(in_reg2_read_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_imm(out_imm),
        .out_aluop(out_aluop), .out_alusel(out_alusel),
        .out_reg_write_en(out_reg_write_en), .out_reg_write_addr(out_reg_write_addr),
        .out_reg1_read_addr(out_reg1_read_addr), .out_reg2_read_addr(out_reg2_read_addr),
        .out_reg1_read_en(out_reg1_read_en), .out_reg2_read_en(out_reg2_read_en),
        .out_ine(out_ine), .wb_en(wb_en), .wb_addr(wb_addr), .count(count)
    );

    function automatic bundle_t mk(input logic [31:0] pc, input logic [7:0] op,
                                   input logic [2:0] sel, input logic iv,
                                   input logic we, input logic [4:0] wa,
                                   input logic r1e, input logic [4:0] r1a,
                                   input logic r2e, input logic [4:0] r2a,
                                   input logic [31:0] imm);
        bundle_t b;
        b.pc = pc; b.op = op; b.sel = sel; b.iv = iv; b.we = we; b.wa = wa;
        b.r1e = r1e; b.r1a = r1a; b.r2e = r2e; b.r2a = r2a; b.imm = imm;
        return b;
    endfunction

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // Reference view of what execute must see for a given decoder bundle.
    function automatic logic [125:0] exp_of(input bundle_t b);
        if (b.iv)
            return {b.pc, inst_of(b.pc), b.imm, b.op, b.sel, b.we, b.wa,
                    b.r1e, b.r1a, b.r2e, b.r2a, 1'b0};
        return {b.pc, inst_of(b.pc), b.imm, ALU_NOP, ALU_SEL_NOP, 1'b0, b.wa,
                1'b0, b.r1a, 1'b0, b.r2a, 1'b1};
    endfunction

    task automatic drive(input bundle_t b);
        in_pc = b.pc; in_inst = inst_of(b.pc); in_imm = b.imm;
        in_inst_valid = b.iv; in_reg_write_en = b.we; in_reg_write_addr = b.wa;
        in_aluop = b.op; in_alusel = b.sel;
        in_reg1_read_en = b.r1e; in_reg1_read_addr = b.r1a;
        in_reg2_read_en = b.r2e; in_reg2_read_addr = b.r2a;
        in_valid = 1'b1;
    endtask

    // Push a bundle that must be accepted; returns #1 after the accepting edge.
    task automatic push_one(input bundle_t b);
        drive(b);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL push_ready pc=%h got=%b required=1", b.pc, in_ready);
        end
        @(posedge clk); #1;
        exp_q.push_back(exp_of(b));
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain pending=%0d required=0", tag, exp_q.size());
        end
    endtask

    // Issue monitor: sampled mid-cycle, the issue happens at the next edge.
    always @(negedge clk) begin
        logic [125:0] act, e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            act = {out_pc, out_inst, out_imm, out_aluop, out_alusel, out_reg_write_en,
                   out_reg_write_addr, out_reg1_read_en, out_reg1_read_addr,
                   out_reg2_read_en, out_reg2_read_addr, out_ine};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL issue_unexpected got=%h required=none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_err++;
                    $display("FAIL issue_fields got=%h required=%h", act, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 6;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
        if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d required=0", count); end
        if (out_aluop !== ALU_NOP) begin n_err++; $display("FAIL rst_aluop got=%h required=%h", out_aluop, ALU_NOP); end
        if (out_alusel !== ALU_SEL_NOP) begin n_err++; $display("FAIL rst_alusel got=%h required=%h", out_alusel, ALU_SEL_NOP); end
        if ({out_pc, out_imm, out_ine, out_reg_write_en} !== '0) begin
            n_err++; $display("FAIL rst_fields got=%h/%h/%b/%b required=0", out_pc, out_imm, out_ine, out_reg_write_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ori();
        bundle_t b;
        b = mk(32'h0000_1000, ALU_ORI, ALU_SEL_LOGIC, 1, 1, 5'd5, 1, 5'd3, 0, 5'd0, 32'h0000_0FFF);
        out_ready = 1'b1;
        drive(b);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL ori_no_bypass got=%b required=0", out_valid); end
        @(posedge clk); #1;
        exp_q.push_back(exp_of(b));
        in_valid = 1'b0;
        n_cmp += 3;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL ori_valid got=%b required=1", out_valid); end
        if (out_aluop !== ALU_ORI) begin n_err++; $display("FAIL ori_aluop got=%h required=%h", out_aluop, ALU_ORI); end
        if (out_imm !== 32'h0000_0FFF) begin n_err++; $display("FAIL ori_imm got=%h required=00000fff", out_imm); end
        @(posedge clk); #1;
        n_cmp += 2;
        if (dut.u_scoreboard.busy[5] !== 1'b1) begin n_err++; $display("FAIL ori_busy5 got=%b required=1", dut.u_scoreboard.busy[5]); end
        if (count !== 3'd0) begin n_err++; $display("FAIL ori_count got=%0d required=0", count); end
    endtask

    task automatic test_hazard();
        wb_en = 1'b1; wb_addr = 5'd5;
        @(posedge clk); #1;
        wb_en = 1'b0;
        n_cmp++;
        if (dut.u_scoreboard.busy[5] !== 1'b0) begin n_err++; $display("FAIL wb_clear5 got=%b required=0", dut.u_scoreboard.busy[5]); end
        push_one(mk(32'h0000_2000, ALU_ADDI, ALU_SEL_ARITH, 1, 1, 5'd5, 1, 5'd1, 0, 5'd0, 32'h0000_0010));
        push_one(mk(32'h0000_2004, ALU_SLTI, ALU_SEL_ARITH, 1, 1, 5'd6, 1, 5'd5, 0, 5'd0, 32'h0000_0020));
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL slti_stall got=%b required=0", out_valid); end
        if (count !== 3'd1) begin n_err++; $display("FAIL slti_count got=%0d required=1", count); end
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL slti_hold got=%b required=0", out_valid); end
        wb_en = 1'b1; wb_addr = 5'd5;
        #1;
        n_cmp++;
`ifdef DISPATCH_WB_BYPASS_EN
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL slti_wb_cycle got=%b required=1", out_valid); end
`else
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL slti_wb_cycle got=%b required=0", out_valid); end
`endif
        @(posedge clk); #1;
        wb_en = 1'b0;
        n_cmp++;
`ifdef DISPATCH_WB_BYPASS_EN
        if (count !== 3'd0) begin n_err++; $display("FAIL slti_after_wb got=%0d required=0", count); end
`else
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL slti_after_wb got=%b required=1", out_valid); end
`endif
        wait_drain("hazard");
    endtask

    task automatic test_full();
        bundle_t b5;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_one(mk(32'h0000_3000 + 32'(i * 4), ALU_ORI, ALU_SEL_LOGIC, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'(i)));
        n_cmp += 2;
        if (count !== 3'd4) begin n_err++; $display("FAIL full_count got=%0d required=4", count); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b required=0", in_ready); end
        b5 = mk(32'h0000_3010, ALU_ADDI, ALU_SEL_ARITH, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'h55);
        drive(b5);
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL full_hold got=%0d/%b required=4/0", count, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_ready got=%b required=0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (count !== 3'd3) begin n_err++; $display("FAIL full_after_pop got=%0d required=3", count); end
        @(posedge clk); #1;
        exp_q.push_back(exp_of(b5));
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd4) begin n_err++; $display("FAIL full_fifth got=%0d required=4", count); end
        out_ready = 1'b1;
        wait_drain("full");
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push_one(mk(32'h0000_4000, ALU_ORI, ALU_SEL_LOGIC, 1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 32'h1));
        push_one(mk(32'h0000_4004, ALU_ORI, ALU_SEL_LOGIC, 1, 1, 5'd10, 0, 5'd0, 0, 5'd0, 32'h2));
        push_one(mk(32'h0000_4008, ALU_ORI, ALU_SEL_LOGIC, 1, 1, 5'd11, 0, 5'd0, 0, 5'd0, 32'h3));
        busy_snap = dut.u_scoreboard.busy;
        out_ready = 1'b1;
        flush = 1'b1;
        drive(mk(32'h0000_400C, ALU_ORI, ALU_SEL_LOGIC, 1, 1, 5'd12, 0, 5'd0, 0, 5'd0, 32'h4));
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b required=0", out_valid); end
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        n_cmp += 2;
        if (count !== 3'd0) begin n_err++; $display("FAIL flush_count got=%0d required=0", count); end
        if (dut.u_scoreboard.busy !== busy_snap) begin
            n_err++; $display("FAIL flush_busy got=%h required=%h", dut.u_scoreboard.busy, busy_snap);
        end
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_lost got=%0d/%b required=0/0", count, out_valid);
        end
    endtask

    task automatic test_nop_r0();
        out_ready = 1'b1;
        // Reads r6, which is still busy; a sanitised entry must not wait on it.
        push_one(mk(32'h0000_5000, ALU_ORI, ALU_SEL_LOGIC, 0, 1, 5'd8, 1, 5'd6, 1, 5'd6, 32'h77));
        wait_drain("nop");
        n_cmp++;
        if (dut.u_scoreboard.busy[8] !== 1'b0) begin n_err++; $display("FAIL nop_busy8 got=%b required=0", dut.u_scoreboard.busy[8]); end
        push_one(mk(32'h0000_5004, ALU_ADDI, ALU_SEL_ARITH, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 32'h1));
        wait_drain("r0");
        n_cmp++;
        if (dut.u_scoreboard.busy[0] !== 1'b0) begin n_err++; $display("FAIL r0_busy got=%b required=0", dut.u_scoreboard.busy[0]); end
    endtask

    task automatic test_set_wins_reset();
        out_ready = 1'b0;
        push_one(mk(32'h0000_6000, ALU_ADDI, ALU_SEL_ARITH, 1, 1, 5'd7, 0, 5'd0, 0, 5'd0, 32'h7));
        out_ready = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd7;
        @(posedge clk); #1;
        out_ready = 1'b0;
        wb_en = 1'b0;
        n_cmp += 2;
        if (dut.u_scoreboard.busy[7] !== 1'b1) begin n_err++; $display("FAIL set_wins_busy7 got=%b required=1", dut.u_scoreboard.busy[7]); end
        if (count !== 3'd0) begin n_err++; $display("FAIL set_wins_count got=%0d required=0", count); end
        push_one(mk(32'h0000_6004, ALU_ORI, ALU_SEL_LOGIC, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'h8));
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid got=%b required=1", out_valid); end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_cmp += 4;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid got=%b required=0", out_valid); end
        if (count !== 3'd0) begin n_err++; $display("FAIL async_rst_count got=%0d required=0", count); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_ready got=%b required=1", in_ready); end
        if (dut.u_scoreboard.busy !== 32'h0) begin n_err++; $display("FAIL async_rst_busy got=%h required=0", dut.u_scoreboard.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ori();
        test_hazard();
        test_full();
        test_flush();
        test_nop_r0();
        test_set_wins_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
